cic_interpolator: RTL and testbench
===================================

Name: cic_interpolator

Overview:
- Transmit-direction counterpart of the receive-side notch/decimation chain: a CIC interpolator that upsamples by R = 2^LOG2_R.
- Runs on the shared 18 MHz `clk`; no CDC.
- Derives the output sample strobe internally (every CLK_DIV clocks, 6 MHz by default) and pulls one input sample every R strobes (3 MHz).
- Feeds DAC-side logic; output is gain-normalised to unity DC gain.

Parameters:
- DATA_WIDTH, 16, signed input/output sample width.
- N, 3, number of comb stages and number of integrator stages.
- LOG2_R, 1, log2 of interpolation ratio R.
- CLK_DIV, 3, clk cycles per output strobe (18 MHz / 3 = 6 MHz).

Ports:
- clk  in  1  system clock, 18 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- x_in  in  DATA_WIDTH  signed input sample.
- in_valid  in  1  producer has x_in available.
- in_ready  out  1  one-cycle pulse: block consumes x_in this cycle.
- x_out  out  DATA_WIDTH  signed interpolated sample, held between strobes.
- out_valid  out  1  one-cycle pulse when x_out updates.
- underrun  out  1  one-cycle pulse: in_ready pulsed with in_valid low.

Behaviour:
- Reset (async, rst_n low): all outputs, div counter, phase counter, comb delays and integrators go to 0; in_ready and out_valid are low during reset.
- Reset mid-operation discards all state; the first in_ready follows the first tick after release.
- Timebase:
  - div counts 0..CLK_DIV-1 and wraps.
  - tick = (div == CLK_DIV-1).
  - phase counts 0..R-1 on ticks and wraps.
- in_ready = tick && phase == 0 (combinational from registers). Sample s = in_valid ? x_in : 0.
- underrun is registered: asserted the cycle after in_ready && !in_valid.
- in_valid is ignored when in_ready is low. The producer holds x_in until the in_ready pulse.
- Internal width W = DATA_WIDTH + N*LOG2_R. All comb and integrator arithmetic is two's-complement modulo 2^W; wrap is required, not an error.
- Combs, on in_ready cycles only, M = 1:
  - c0 = sign-extended s; c_k = c_{k-1} - d_k, computed combinationally through all N stages.
  - d_k <= c_{k-1}.
- Upsampler: u = c_N when phase == 0, else 0 (zero-stuffing).
- Integrators, on every tick, registered and pipelined:
  - I_1 <= I_1 + u.
  - I_k <= I_k + I_{k-1} (old register value), for k = 2..N.
- Output, on every tick:
  - x_out <= sat_DATA_WIDTH(I_N >>> SHIFT), with SHIFT = (N-1)*LOG2_R; arithmetic shift, symmetric-clip saturation to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - out_valid <= 1 for one cycle.
- Latency: a sample consumed on tick T first affects x_out on tick T+N; out_valid is high the cycle after that tick.
- Transfer function (pre-shift): ((1 - z^-R)/(1 - z^-1))^N at output rate. DC gain R^(N-1) before shift, exactly 1 after.
- Simultaneous tick and in_ready: the comb update and integrator update happen in the same cycle; integrators use the new u.

Decomposition:
- Package cic_pkg holds:
  - the W and SHIFT derivation functions;
  - the saturation function;
  - constants DEF_N, DEF_LOG2_R, DEF_CLK_DIV.
- One sub-module, cic_int_stage: a parameterised W-bit accumulator with tick enable and async reset, instantiated N times via generate. Combs stay inline.

Test Plan (defaults):
1. Impulse: one sample 4000, then zeros with in_valid held high -> x_out = 1000, 3000, 3000, 1000 on ticks T+3..T+6, then 0 forever; out_valid pulses every 3 clk.
2. DC +1000 continuous -> settles to exactly 1000 within 6 ticks and holds; in_ready pulses every 6 clk.
3. Full-scale extremes:
   - DC -32768 -> steady x_out = -32768.
   - DC +32767 -> steady +32767.
   - Alternating +32767/-32768 -> no wrap artifacts on output; saturation is correct at peaks.
4. Underrun: drop in_valid for one in_ready slot during DC 1000 -> underrun pulses once; output equals 1000 convolved with the kernel using 0 in that slot (dips to 750 and 250, recovers to 1000).
5. Reset mid-stream: assert rst_n low asynchronously between ticks -> x_out, out_valid, in_ready go to 0 immediately. After release, the first in_ready comes CLK_DIV clk later, and the impulse response of test 1 repeats exactly.
6. Random stimulus for 10k samples against a bit-accurate reference model -> x_out matches every tick; in_ready/out_valid spacing is constant.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared derivations and helpers for the CIC interpolator.
//   calc_w     : internal datapath width DATA_WIDTH + N*LOG2_R
//   calc_shift : output normalisation shift (N-1)*LOG2_R
//   sat_clip   : symmetric clip of a 64-bit signed value to a dw-bit range
package cic_pkg;

  localparam int unsigned DEF_N       = 3;
  localparam int unsigned DEF_LOG2_R  = 1;
  localparam int unsigned DEF_CLK_DIV = 3;

  function automatic int unsigned calc_w(input int unsigned dw,
                                         input int unsigned n,
                                         input int unsigned log2r);
    return dw + n * log2r;
  endfunction

  function automatic int unsigned calc_shift(input int unsigned n,
                                             input int unsigned log2r);
    return (n - 1) * log2r;
  endfunction

  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                  input int unsigned       dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cic_interpolator_if.sv
// Sample stream bundle between a producer (master) and the interpolator (slave).
//   x_in/in_valid   : producer sample and availability
//   in_ready        : interpolator consumes x_in this cycle
//   x_out/out_valid : interpolated sample and its update pulse
//   underrun        : a consume slot found in_valid low
interface cic_interpolator_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] x_in;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] x_out;
  logic                         out_valid;
  logic                         underrun;

  modport master (
    output x_in, in_valid,
    input  in_ready, x_out, out_valid, underrun
  );

  modport slave (
    input  x_in, in_valid,
    output in_ready, x_out, out_valid, underrun
  );
endinterface

// File: rtl/cic_int_stage.sv
// One CIC integrator: W-bit wrapping accumulator advanced on i_en.
//   clk, rst_n : clock, async active-low reset
//   i_en       : advance enable (output-rate tick)
//   i_add      : addend
//   o_acc      : registered accumulator value
module cic_int_stage #(
  parameter int unsigned W = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic signed [W-1:0] i_add,
  output logic signed [W-1:0] o_acc
);

  logic signed [W-1:0] r_acc;

  // Modulo-2^W accumulation; wrap is intended
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_acc <= '0;
    else if (i_en) r_acc <= r_acc + i_add;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator, ratio R = 2^LOG2_R, N comb + N integrator stages,
// unity DC gain after shift and saturation.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of cic_interpolator_if (x_in/in_valid in,
//                in_ready/x_out/out_valid/underrun out)
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N          = DEF_N,
  parameter int unsigned LOG2_R     = DEF_LOG2_R,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV
) (
  input  logic          clk,
  input  logic          rst_n,
  cic_interpolator_if.slave bus
);

  localparam int unsigned R     = 1 << LOG2_R;
  localparam int unsigned W     = calc_w(DATA_WIDTH, N, LOG2_R);
  localparam int unsigned SHIFT = calc_shift(N, LOG2_R);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PH_W  = (LOG2_R > 0) ? LOG2_R : 1;

  logic [DIV_W-1:0]             r_div;
  logic [PH_W-1:0]              r_phase;
  logic                         w_tick;
  logic                         w_phase0;
  logic                         w_in_ready;
  logic signed [DATA_WIDTH-1:0] w_s;
  logic signed [W-1:0]          w_cin [1:N];
  logic signed [W-1:0]          w_cn;
  logic signed [W-1:0]          r_d   [1:N];
  logic signed [W-1:0]          w_u;
  logic signed [W-1:0]          w_acc [1:N];
  logic signed [W-1:0]          w_shifted;
  logic signed [DATA_WIDTH-1:0] r_x_out;
  logic                         r_out_valid;
  logic                         r_underrun;

  assign w_tick     = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_phase0   = (r_phase == '0);
  assign w_in_ready = w_tick && w_phase0;

  // Output-rate timebase and input-rate phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_phase <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) r_phase <= (r_phase == PH_W'(R - 1)) ? '0 : r_phase + PH_W'(1);
    end
  end

  // A missing sample enters the filter as zero
  assign w_s = bus.in_valid ? bus.x_in : '0;

  // Comb chain, combinational through all stages; w_cin[k] is c_{k-1}
  always_comb begin
    logic signed [W-1:0] v_c;
    v_c = W'(w_s);
    for (int k = 1; k <= int'(N); k++) begin
      w_cin[k] = v_c;
      v_c      = v_c - r_d[k];
    end
    w_cn = v_c;
  end

  // Comb delays advance only at input rate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= int'(N); k++) r_d[k] <= '0;
    end else if (w_in_ready) begin
      for (int k = 1; k <= int'(N); k++) r_d[k] <= w_cin[k];
    end
  end

  // Zero-stuffing upsampler
  assign w_u = w_phase0 ? w_cn : '0;

  // Pipelined integrators: stage k adds the previous register value of stage k-1
  for (genvar g = 1; g <= N; g++) begin : g_int
    logic signed [W-1:0] w_add;
    if (g == 1) begin : g_first
      assign w_add = w_u;
    end else begin : g_rest
      assign w_add = w_acc[g-1];
    end
    cic_int_stage #(.W(W)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_tick),
      .i_add (w_add),
      .o_acc (w_acc[g])
    );
  end

  assign w_shifted = w_acc[N] >>> SHIFT;

  // Normalised, saturated output and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_out     <= '0;
      r_out_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_tick) r_x_out <= DATA_WIDTH'(sat_clip(64'(w_shifted), DATA_WIDTH));
      r_out_valid <= w_tick;
      r_underrun  <= w_in_ready && !bus.in_valid;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.x_out     = r_x_out;
  assign bus.out_valid = r_out_valid;
  assign bus.underrun  = r_underrun;

endmodule

// File: tb/tb_cic_interpolator.sv
// Scoreboard bench: expected output per tick comes from a direct convolution
// of the zero-stuffed input with the CIC kernel, then shift and clip.
module tb_cic_interpolator;
  import cic_pkg::*;

  localparam int unsigned DW      = 16;
  localparam int unsigned N       = DEF_N;
  localparam int unsigned LOG2_R  = DEF_LOG2_R;
  localparam int unsigned CLK_DIV = DEF_CLK_DIV;
  localparam int          R       = 1 << LOG2_R;
  localparam int          SHIFT   = (int'(N) - 1) * int'(LOG2_R);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cic_interpolator_if #(.DATA_WIDTH(DW)) bus ();

  cic_interpolator #(
    .DATA_WIDTH (DW),
    .N          (N),
    .LOG2_R     (LOG2_R),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int h[$];
  int u_hist[$];
  int exp_q[$];
  int obs_log[$];
  bit stop    = 1'b0;
  int cyc     = 0;
  int last_ir = -1;
  int last_ov = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string name, input int idx, input int exp);
    if (idx >= obs_log.size()) check(name, -999999, exp);
    else                       check(name, obs_log[idx], exp);
  endtask

  // Kernel = N-fold convolution of a length-R boxcar
  task automatic build_kernel();
    int tmp[$];
    h = {1};
    for (int s = 0; s < int'(N); s++) begin
      tmp = {};
      for (int i = 0; i < h.size() + R - 1; i++) tmp.push_back(0);
      for (int i = 0; i < h.size(); i++)
        for (int j = 0; j < R; j++) tmp[i+j] += h[i];
      h = tmp;
    end
  endtask

  // Expected x_out after output tick t (integrator pipeline delays by N ticks)
  function automatic int model_out(input int t);
    int m, acc, y;
    m = t - int'(N);
    if (m < 0) return 0;
    acc = 0;
    for (int k = 0; k < h.size(); k++)
      if (m - k >= 0) acc += h[k] * u_hist[m-k];
    y = acc >>> SHIFT;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic push_sample(input int s);
    for (int p = 0; p < R; p++) begin
      u_hist.push_back((p == 0) ? s : 0);
      exp_q.push_back(model_out(u_hist.size() - 1));
    end
  endtask

  task automatic send(input bit v, input int x);
    int n;
    bus.in_valid = v;
    bus.x_in     = DW'(x);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", int'(bus.in_ready), 1);
    end else begin
      push_sample(v ? x : 0);
      @(posedge clk);
      #1;
      check("underrun", int'(bus.underrun), int'(!v));
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    u_hist.delete();
    obs_log.delete();
    last_ir = -1;
    last_ov = -1;
  endtask

  task automatic impulse_checks();
    int t0;
    t0 = u_hist.size();
    send(1'b1, 4000);
    repeat (6) send(1'b1, 0);
    check_obs("imp_t3", t0 + 3, 1000);
    check_obs("imp_t4", t0 + 4, 3000);
    check_obs("imp_t5", t0 + 5, 3000);
    check_obs("imp_t6", t0 + 6, 1000);
    check_obs("imp_t7", t0 + 7, 0);
    check_obs("imp_t10", t0 + 10, 0);
  endtask

  // Monitor: pops the scoreboard on every out_valid, checks strobe spacing
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (bus.in_ready) begin
        if (last_ir >= 0) check("in_ready_gap", cyc - last_ir, int'(CLK_DIV) * R);
        last_ir = cyc;
      end
      if (bus.out_valid) begin
        if (last_ov >= 0) check("out_valid_gap", cyc - last_ov, int'(CLK_DIV));
        last_ov = cyc;
        obs_log.push_back(int'(bus.x_out));
        if (!stop) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got x_out=%0d with no expected value queued", bus.x_out);
          end else begin
            e = exp_q.pop_front();
            check("x_out", int'(bus.x_out), e);
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, cnt, n;
    build_kernel();
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x_out", int'(bus.x_out), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_underrun", int'(bus.underrun), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse response
    impulse_checks();

    // DC levels including full scale
    repeat (8) send(1'b1, 1000);
    check_obs("dc_1000", obs_log.size() - 1, 1000);
    repeat (8) send(1'b1, -32768);
    check_obs("dc_min", obs_log.size() - 1, -32768);
    repeat (8) send(1'b1, 32767);
    check_obs("dc_max", obs_log.size() - 1, 32767);
    for (int i = 0; i < 12; i++) send(1'b1, (i % 2 == 0) ? -32768 : 32767);

    // Underrun slot inside a DC 1000 stream
    repeat (8) send(1'b1, 1000);
    t0 = u_hist.size();
    send(1'b0, 1000);
    repeat (6) send(1'b1, 1000);
    check_obs("und_t3", t0 + 3, 750);
    check_obs("und_t4", t0 + 4, 250);
    check_obs("und_t5", t0 + 5, 250);
    check_obs("und_t6", t0 + 6, 750);
    check_obs("und_t7", t0 + 7, 1000);

    // Asynchronous reset right after a tick edge
    repeat (4) send(1'b1, 1000);
    #2;
    rst_n = 1'b0;
    flush_model();
    #1;
    check("mid_rst_x_out", int'(bus.x_out), 0);
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      cnt++;
      #1;
      if (bus.in_ready) break;
    end
    check("first_ready_latency", cnt + 1, int'(CLK_DIV));
    impulse_checks();

    // Random stream with occasional underruns
    for (int i = 0; i < 10000; i++) begin
      bit v;
      int x;
      v = ($urandom_range(0, 9) != 0);
      x = int'($urandom_range(0, 65535)) - 32768;
      send(v, x);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    stop = 1'b1;
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
